// File: rtl/ascon_ctrl_fsm.sv
// ascon_ctrl_fsm -- sequencing controller for the ASCON-128a encryption datapath.
//
// Walks one session through initialisation (p^a), AD absorption (p^b per
// block), PT absorption / ciphertext generation (p^b per block) and
// finalisation (p^a), then flags the tag. One permutation round per cycle.
//
// Ports
//   clock_i               system clock, rising edge
//   reset_i               synchronous reset, active-high
//   start_i               start pulse, sampled only in IDLE
//   data_valid_i          a 128-bit block is present on the data bus
//   data_is_ad_i          1 = block is associated data, 0 = plaintext
//   data_last_i           block is the last of its phase
//   data_ready_o          block is consumed this cycle when data_valid_i=1
//   round_o               round-constant index for the permutation
//   init_state_o          select IV||K||N as permutation input
//   en_state_o            state register load enable
//   ena_xor_up_o          xor_up of the data block into S0/S1
//   ena_xor_final_key_o   XOR K into S2/S3 at permutation input
//   ena_xor_down_key_o    XOR K into S3/S4 at permutation output
//   ena_xor_ds_o          XOR domain-separation bit into S4
//   cipher_valid_o        S0||S1 after xor_up is a ciphertext block
//   tag_valid_o           S3||S4 holds the tag
//   done_o                one-cycle end-of-operation pulse
//   busy_o                controller is not in IDLE
//   error_o               one-cycle pulse: block of the wrong phase dropped
module ascon_ctrl_fsm #(
  parameter int ROUNDS_A = 12,
  parameter int ROUNDS_B = 8,
  parameter int CNT_W    = 4
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             data_valid_i,
  input  logic             data_is_ad_i,
  input  logic             data_last_i,
  output logic             data_ready_o,
  output logic [CNT_W-1:0] round_o,
  output logic             init_state_o,
  output logic             en_state_o,
  output logic             ena_xor_up_o,
  output logic             ena_xor_final_key_o,
  output logic             ena_xor_down_key_o,
  output logic             ena_xor_ds_o,
  output logic             cipher_valid_o,
  output logic             tag_valid_o,
  output logic             done_o,
  output logic             busy_o,
  output logic             error_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INIT_P  = 3'd1,
    S_WAIT_AD = 3'd2,
    S_AD_P    = 3'd3,
    S_WAIT_PT = 3'd4,
    S_PT_P    = 3'd5,
    S_FINAL_P = 3'd6,
    S_TAG     = 3'd7
  } state_t;

  // Last round index of every permutation, and first round index of p^b.
  localparam logic [CNT_W-1:0] C_LAST     = CNT_W'(ROUNDS_A - 1);
  localparam logic [CNT_W-1:0] C_PB_FIRST = CNT_W'(ROUNDS_A - ROUNDS_B);
  localparam logic [CNT_W-1:0] C_ZERO     = CNT_W'(0);
  localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_last;     // last-flag of the AD block being absorbed
  logic             w_round_end;

  // Every permutation phase ends on the same round index; the counter never
  // advances past it because leaving the phase clears it.
  assign w_round_end = (r_cnt == C_LAST);

  // State and round-counter sequencing.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_state <= S_IDLE;
      r_cnt   <= C_ZERO;
      r_last  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_state <= S_INIT_P;
            r_cnt   <= C_ZERO;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_INIT_P: begin
          if (w_round_end) begin
            r_state <= S_WAIT_AD;
            r_cnt   <= C_ZERO;
          end else begin
            r_cnt <= r_cnt + C_ONE;
          end
        end
        S_WAIT_AD: begin
          // The acceptance cycle is already the first p^b round.
          if (data_valid_i && data_is_ad_i) begin
            r_state <= S_AD_P;
            r_cnt   <= C_PB_FIRST + C_ONE;
            r_last  <= data_last_i;
          end else begin
            r_state <= S_WAIT_AD;
          end
        end
        S_AD_P: begin
          if (w_round_end) begin
            r_state <= r_last ? S_WAIT_PT : S_WAIT_AD;
            r_cnt   <= C_ZERO;
          end else begin
            r_cnt <= r_cnt + C_ONE;
          end
        end
        S_WAIT_PT: begin
          if (data_valid_i && !data_is_ad_i) begin
            // Last PT block starts finalisation at round 0 in the same cycle.
            if (data_last_i) begin
              r_state <= S_FINAL_P;
              r_cnt   <= C_ONE;
            end else begin
              r_state <= S_PT_P;
              r_cnt   <= C_PB_FIRST + C_ONE;
            end
          end else begin
            r_state <= S_WAIT_PT;
          end
        end
        S_PT_P: begin
          if (w_round_end) begin
            r_state <= S_WAIT_PT;
            r_cnt   <= C_ZERO;
          end else begin
            r_cnt <= r_cnt + C_ONE;
          end
        end
        S_FINAL_P: begin
          if (w_round_end) begin
            r_state <= S_TAG;
            r_cnt   <= C_ZERO;
          end else begin
            r_cnt <= r_cnt + C_ONE;
          end
        end
        S_TAG: begin
          r_state <= S_IDLE;
          r_cnt   <= C_ZERO;
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= C_ZERO;
        end
      endcase
    end
  end

  // Output decode: pure state decode except in the two WAIT states, where the
  // datapath must act in the same cycle the block is handed over.
  always_comb begin
    data_ready_o        = 1'b0;
    round_o             = r_cnt;
    init_state_o        = 1'b0;
    en_state_o          = 1'b0;
    ena_xor_up_o        = 1'b0;
    ena_xor_final_key_o = 1'b0;
    ena_xor_down_key_o  = 1'b0;
    ena_xor_ds_o        = 1'b0;
    cipher_valid_o      = 1'b0;
    tag_valid_o         = 1'b0;
    done_o              = 1'b0;
    error_o             = 1'b0;
    busy_o              = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        round_o = C_ZERO;
      end
      S_INIT_P: begin
        en_state_o         = 1'b1;
        init_state_o       = (r_cnt == C_ZERO);
        ena_xor_down_key_o = w_round_end;
      end
      S_WAIT_AD: begin
        data_ready_o = 1'b1;
        if (data_valid_i) begin
          if (data_is_ad_i) begin
            ena_xor_up_o = 1'b1;
            en_state_o   = 1'b1;
            round_o      = C_PB_FIRST;
          end else begin
            error_o = 1'b1;
          end
        end else begin
          error_o = 1'b0;
        end
      end
      S_AD_P: begin
        en_state_o   = 1'b1;
        ena_xor_ds_o = w_round_end && r_last;
      end
      S_WAIT_PT: begin
        data_ready_o = 1'b1;
        if (data_valid_i) begin
          if (!data_is_ad_i) begin
            ena_xor_up_o   = 1'b1;
            cipher_valid_o = 1'b1;
            en_state_o     = 1'b1;
            if (data_last_i) begin
              ena_xor_final_key_o = 1'b1;
              round_o             = C_ZERO;
            end else begin
              round_o = C_PB_FIRST;
            end
          end else begin
            error_o = 1'b1;
          end
        end else begin
          error_o = 1'b0;
        end
      end
      S_PT_P: begin
        en_state_o = 1'b1;
      end
      S_FINAL_P: begin
        en_state_o         = 1'b1;
        ena_xor_down_key_o = w_round_end;
      end
      S_TAG: begin
        tag_valid_o = 1'b1;
        done_o      = 1'b1;
      end
      default: begin
        round_o = C_ZERO;
      end
    endcase
  end

endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// Directed testbench for ascon_ctrl_fsm. Cycle n is the interval after the
// n-th observed rising edge; inputs are driven 1 time unit after the edge and
// outputs are compared 1 unit later, well before the next edge.
module tb_ascon_ctrl_fsm;

  logic       clock_i = 1'b0;
  logic       reset_i;
  logic       start_i;
  logic       data_valid_i;
  logic       data_is_ad_i;
  logic       data_last_i;
  logic       data_ready_o;
  logic [3:0] round_o;
  logic       init_state_o;
  logic       en_state_o;
  logic       ena_xor_up_o;
  logic       ena_xor_final_key_o;
  logic       ena_xor_down_key_o;
  logic       ena_xor_ds_o;
  logic       cipher_valid_o;
  logic       tag_valid_o;
  logic       done_o;
  logic       busy_o;
  logic       error_o;

  int n_checks = 0;
  int n_errors = 0;

  ascon_ctrl_fsm #(.ROUNDS_A(12), .ROUNDS_B(8), .CNT_W(4)) dut (
    .clock_i             (clock_i),
    .reset_i             (reset_i),
    .start_i             (start_i),
    .data_valid_i        (data_valid_i),
    .data_is_ad_i        (data_is_ad_i),
    .data_last_i         (data_last_i),
    .data_ready_o        (data_ready_o),
    .round_o             (round_o),
    .init_state_o        (init_state_o),
    .en_state_o          (en_state_o),
    .ena_xor_up_o        (ena_xor_up_o),
    .ena_xor_final_key_o (ena_xor_final_key_o),
    .ena_xor_down_key_o  (ena_xor_down_key_o),
    .ena_xor_ds_o        (ena_xor_ds_o),
    .cipher_valid_o      (cipher_valid_o),
    .tag_valid_o         (tag_valid_o),
    .done_o              (done_o),
    .busy_o              (busy_o),
    .error_o             (error_o)
  );

  always #5 clock_i = ~clock_i;

  // Output vector layout: {ready, round[3:0], init, en, xup, fkey, dkey, ds,
  // cipher, tag, done, busy, error}
  function automatic logic [16:0] obs();
    return {data_ready_o, round_o, init_state_o, en_state_o, ena_xor_up_o,
            ena_xor_final_key_o, ena_xor_down_key_o, ena_xor_ds_o,
            cipher_valid_o, tag_valid_o, done_o, busy_o, error_o};
  endfunction

  function automatic logic [16:0] mk(input logic rdy, input logic [3:0] rnd,
                                     input logic ini, input logic en,
                                     input logic xup, input logic fk,
                                     input logic dk, input logic ds,
                                     input logic cv, input logic tv,
                                     input logic dn, input logic bsy,
                                     input logic err);
    return {rdy, rnd, ini, en, xup, fk, dk, ds, cv, tv, dn, bsy, err};
  endfunction

  task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic st, input logic v, input logic ad, input logic lst);
    start_i      = st;
    data_valid_i = v;
    data_is_ad_i = ad;
    data_last_i  = lst;
  endtask

  // Compare outputs of the current cycle, then advance to the next one.
  task automatic step(input string tag, input logic [16:0] exp);
    #1;
    check(tag, obs(), exp);
    @(posedge clock_i);
    #1;
  endtask

  // Cycle 0 (start pulse) through cycle 12; returns at the start of cycle 13.
  task automatic run_init(input string tag);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    step({tag, "_start"}, 17'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 1; c <= 12; c++) begin
      step({tag, "_init"}, mk(1'b0, 4'(c - 1), c == 1, 1'b1, 1'b0, 1'b0,
                              c == 12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    end
  endtask

  int n_ready;
  int n_cipher;

  initial begin
    reset_i = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset held 3 cycles, then idle with start low.
    for (int i = 0; i < 3; i++) begin
      @(posedge clock_i);
      #1;
      #1;
      check("reset_zero", obs(), 17'd0);
    end
    reset_i = 1'b0;
    @(posedge clock_i);
    #1;
    for (int i = 0; i < 2; i++) step("idle_zero", 17'd0);

    // Single AD + single PT session.
    run_init("single");
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    step("single_ad_acc", mk(1'b1, 4'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                             1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 14; c <= 20; c++) begin
      step("single_ad_p", mk(1'b0, 4'(c - 9), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                             c == 20, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    end
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    step("single_pt_acc", mk(1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
                             1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 22; c <= 32; c++) begin
      step("single_final", mk(1'b0, 4'(c - 21), 1'b0, 1'b1, 1'b0, 1'b0,
                              c == 32, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    end
    step("single_tag", mk(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                          1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
    step("single_back_idle", 17'd0);

    // 2 AD + 3 PT with valid held high; start_i also pulsed during AD_P.
    run_init("multi");
    n_ready  = 0;
    n_cipher = 0;
    for (int c = 13; c <= 57; c++) begin
      logic [16:0] e;
      drive(c >= 14 && c <= 20, c <= 45, c < 29, (c >= 21 && c < 29) || c == 45);
      if (c < 45) begin
        int j;
        int blk;
        j   = (c - 13) % 8;
        blk = (c - 13) / 8;
        e = mk(j == 0, 4'(4 + j), 1'b0, 1'b1, j == 0, 1'b0, 1'b0,
               j == 7 && blk == 1, j == 0 && blk >= 2, 1'b0, 1'b0, 1'b1, 1'b0);
      end else if (c == 45) begin
        e = mk(1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
               1'b0, 1'b1, 1'b0);
      end else if (c <= 56) begin
        e = mk(1'b0, 4'(c - 45), 1'b0, 1'b1, 1'b0, 1'b0, c == 56, 1'b0, 1'b0,
               1'b0, 1'b0, 1'b1, 1'b0);
      end else begin
        e = mk(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
               1'b1, 1'b1, 1'b0);
      end
      #1;
      if (data_ready_o === 1'b1) n_ready++;
      if (cipher_valid_o === 1'b1) n_cipher++;
      check("multi_cycle", obs(), e);
      @(posedge clock_i);
      #1;
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("multi_ready_count", 17'(n_ready), 17'd5);
    check("multi_cipher_count", 17'(n_cipher), 17'd3);
    step("multi_back_idle", 17'd0);

    // Wrong-phase blocks are dropped with a one-cycle error pulse.
    run_init("err");
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    step("err_pt_in_wait_ad", mk(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    step("err_still_wait_ad", mk(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    step("err_ad_after", mk(1'b1, 4'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                            1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 16; c <= 22; c++) begin
      step("err_ad_p", mk(1'b0, 4'(c - 11), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                          c == 22, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    end
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    step("err_ad_in_wait_pt", mk(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    step("err_pt_last", mk(1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
                           1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 25; c <= 29; c++) begin
      step("err_final", mk(1'b0, 4'(c - 24), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                           1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    end

    // Reset during FINAL_P at round 6 abandons the session.
    reset_i = 1'b1;
    step("rst_final_r6", mk(1'b0, 4'd6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                            1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    reset_i = 1'b0;
    for (int i = 0; i < 8; i++) step("rst_idle_no_tag", 17'd0);
    run_init("restart");
    step("restart_wait_ad", mk(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                               1'b0, 1'b0, 1'b0, 1'b1, 1'b0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
